// File: rtl/distance_zone_filter.sv
// Distance post-processing: 4-tap moving average of ultrasonic samples, debounced
// NEAR/OK/FAR zone classification with hysteresis, motor inhibit, buzzer and fault flag.
module distance_zone_filter #(
   parameter int unsigned NEAR_CM     = 7,
   parameter int unsigned FAR_CM      = 80,
   parameter int unsigned HYST_CM     = 3,
   parameter int unsigned DEBOUNCE    = 3,
   parameter int unsigned BUZZ_CYC    = 10_000_000,
   parameter int unsigned TIMEOUT_CYC = 25_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dist_valid,
   input  logic [11:0] dist_cm,
   output logic [11:0] avg_cm,
   output logic [1:0]  zone,
   output logic        motor_off,
   output logic        buzz,
   output logic        sensor_fault
);

   typedef enum logic [1:0] {
      ZONE_UNKNOWN = 2'b00,
      ZONE_NEAR    = 2'b01,
      ZONE_OK      = 2'b10,
      ZONE_FAR     = 2'b11
   } zone_e;

   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
   localparam int BUZZ_W = $clog2(BUZZ_CYC + 1);

   localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(TIMEOUT_CYC);
   localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
   localparam logic [BUZZ_W-1:0] BUZZ_LOAD  = BUZZ_W'(BUZZ_CYC);
   localparam logic [11:0]       NEAR_ENTER = 12'(NEAR_CM);
   localparam logic [11:0]       NEAR_EXIT  = 12'(NEAR_CM + HYST_CM);
   localparam logic [11:0]       FAR_ENTER  = 12'(FAR_CM);
   localparam logic [11:0]       FAR_EXIT   = 12'(FAR_CM - HYST_CM);
   localparam logic [3:0]        DB_TARGET  = 4'(DEBOUNCE);

   logic [11:0]       sampleBuf_q [4];
   logic [11:0]       sampleBuf_d [4];
   logic [13:0]       sum_q, sum_d;
   logic              primed_q, primed_d;
   logic [11:0]       avg_q, avg_d;
   logic              avgNew_q, avgNew_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              fault_q, fault_d;
   logic              sampleOk, expire;

   zone_e             zone_q, cand_q, rawClass;
   logic [3:0]        dbCnt_q, dbNext;
   logic              commit;
   logic              motorOff_q;
   logic [BUZZ_W-1:0] buzzCnt_q;

   assign sampleOk = dist_valid && (dist_cm != 12'd0);

   // First sample after unpriming fills every tap so the average starts at that sample.
   always_comb begin
      sampleBuf_d = sampleBuf_q;
      sum_d       = sum_q;
      primed_d    = primed_q;
      avgNew_d    = 1'b0;
      if (sampleOk) begin
         avgNew_d = 1'b1;
         primed_d = 1'b1;
         if (!primed_q) begin
            for (int i = 0; i < 4; i++) begin
               sampleBuf_d[i] = dist_cm;
            end
            sum_d = {dist_cm, 2'b00};
         end else begin
            sampleBuf_d[0] = dist_cm;
            sampleBuf_d[1] = sampleBuf_q[0];
            sampleBuf_d[2] = sampleBuf_q[1];
            sampleBuf_d[3] = sampleBuf_q[2];
            sum_d = sum_q - 14'(sampleBuf_q[3]) + 14'(dist_cm);
         end
      end else if (expire) begin
         primed_d = 1'b0;
      end
      avg_d = sum_d[13:2];
   end

   always_comb begin
      expire  = !dist_valid && (idle_q == IDLE_LAST);
      idle_d  = idle_q;
      fault_d = fault_q;
      if (dist_valid) begin
         idle_d  = IDLE_W'(1);
         fault_d = 1'b0;
      end else if (idle_q != IDLE_MAX) begin
         idle_d = idle_q + IDLE_W'(1);
         if (expire) begin
            fault_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            sampleBuf_q[i] <= '0;
         end
         sum_q    <= '0;
         primed_q <= 1'b0;
         avg_q    <= '0;
         avgNew_q <= 1'b0;
         idle_q   <= '0;
         fault_q  <= 1'b0;
      end else begin
         sampleBuf_q <= sampleBuf_d;
         sum_q       <= sum_d;
         primed_q    <= primed_d;
         avg_q       <= avg_d;
         avgNew_q    <= avgNew_d;
         idle_q      <= idle_d;
         fault_q     <= fault_d;
      end
   end

   // Hysteresis only widens the band of the zone currently committed.
   always_comb begin
      rawClass = ZONE_OK;
      if ((zone_q == ZONE_NEAR) && (avg_q <= NEAR_EXIT)) begin
         rawClass = ZONE_NEAR;
      end else if ((zone_q == ZONE_FAR) && (avg_q >= FAR_EXIT)) begin
         rawClass = ZONE_FAR;
      end else if (avg_q <= NEAR_ENTER) begin
         rawClass = ZONE_NEAR;
      end else if (avg_q >= FAR_ENTER) begin
         rawClass = ZONE_FAR;
      end
   end

   always_comb begin
      dbNext = (rawClass == cand_q) ? dbCnt_q + 4'd1 : 4'd1;
      commit = avgNew_q && (rawClass != zone_q) && (dbNext == DB_TARGET);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         zone_q     <= ZONE_UNKNOWN;
         cand_q     <= ZONE_UNKNOWN;
         dbCnt_q    <= '0;
         motorOff_q <= 1'b1;
         buzzCnt_q  <= '0;
      end else if (expire) begin
         zone_q     <= ZONE_UNKNOWN;
         cand_q     <= ZONE_UNKNOWN;
         dbCnt_q    <= '0;
         motorOff_q <= 1'b1;
         buzzCnt_q  <= '0;
      end else begin
         if (buzzCnt_q != '0) begin
            buzzCnt_q <= buzzCnt_q - BUZZ_W'(1);
         end
         if (avgNew_q) begin
            if (rawClass == zone_q) begin
               dbCnt_q <= '0;
            end else if (commit) begin
               zone_q     <= rawClass;
               cand_q     <= rawClass;
               dbCnt_q    <= '0;
               motorOff_q <= (rawClass != ZONE_OK);
               if (rawClass == ZONE_NEAR) begin
                  buzzCnt_q <= BUZZ_LOAD;
               end
            end else begin
               cand_q  <= rawClass;
               dbCnt_q <= dbNext;
            end
         end
      end
   end

   assign avg_cm       = avg_q;
   assign zone         = zone_q;
   assign motor_off    = motorOff_q;
   assign buzz         = (buzzCnt_q != '0);
   assign sensor_fault = fault_q;

endmodule
